sc_clock_ctrl: RTL
==================

Name: sc_clock_ctrl

Overview:
Parametrised clock-phase controller for the single-cycle processor. From one fast board clock it produces single-clock enable pulses: a CPU step enable and N memory-phase enables per CPU cycle. This replaces free-running divided clocks with enables on one clock domain. Adds run, halt, single-step and N-step burst modes, plus a retired-cycle counter for debug and the LCD/segment display path.

Parameters:
CPU_DIV, 4, board clocks per CPU cycle; must be ≥2.
MEM_PER_CPU, 2, memory enables per CPU cycle; must divide CPU_DIV.
CNT_W, 32, width of the retired-cycle counter.
BURST_W, 16, width of the burst length.

Ports:
clock  in  1  board clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  level; continuous execution while high.
step  in  1  one-clock pulse; execute exactly one CPU cycle.
burst_start  in  1  one-clock pulse; execute burst_len CPU cycles.
burst_len  in  BURST_W  number of cycles, sampled on burst_start.
halt  in  1  level; stop at the next CPU-cycle boundary. Highest priority.
cpu_en  out  1  one-clock pulse on the last clock of each CPU cycle (CPU register/PC update).
mem_en  out  1  one-clock pulse at the end of each memory sub-phase.
phase  out  clog2(CPU_DIV)  current position in the CPU cycle, 0..CPU_DIV-1.
busy  out  1  high while a CPU cycle is in progress or pending.
done  out  1  one-clock pulse when a step or burst completes.
cycle_count  out  CNT_W  number of cpu_en pulses since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high) values:
  - State IDLE; phase 0; cpu_en, mem_en, busy, done all 0; cycle_count 0; burst counter 0.
  - A reset mid-cycle aborts the cycle immediately. No cpu_en is issued.
- States: IDLE, RUN, STEP, BURST.
- Phase counter:
  - Advances by 1 each clock in RUN, STEP or BURST.
  - Wraps from CPU_DIV-1 to 0.
  - Held at 0 in IDLE.
- Outputs (all registered, asserted the clock after the phase value that triggers them):
  - M = CPU_DIV/MEM_PER_CPU.
  - mem_en = 1 when (phase mod M) == M-1 and the state is not IDLE.
  - cpu_en = 1 when phase == CPU_DIV-1 and the state is not IDLE.
  - cpu_en and mem_en coincide at the end of each cycle.
- Transitions from IDLE, evaluated each clock in priority order halt > burst_start > step > run:
  - halt: stay in IDLE.
  - burst_start with burst_len==0: stay in IDLE; done pulses on the next clock.
  - burst_start with burst_len>0: load remaining=burst_len, go to BURST.
  - step: go to STEP.
  - run: go to RUN.
- Transitions are evaluated only at the cycle boundary (phase==CPU_DIV-1). A CPU cycle is never truncated except by reset.
  - RUN → IDLE if halt or !run at the boundary.
  - STEP → IDLE at the first boundary; done pulses together with cpu_en.
  - BURST: decrement remaining at each boundary. At remaining==1 → IDLE with done. halt at a boundary → IDLE with no done pulse.
- Inputs outside IDLE:
  - step and burst_start are ignored (no queueing).
  - run is ignored in STEP and BURST.
- busy = state != IDLE.
- A same-clock step and run in IDLE selects STEP. run is re-evaluated after done.
- cycle_count increments on every cpu_en, across all modes.

Test Plan:
- CPU_DIV=4, MEM_PER_CPU=2; run held high for 12 clocks → cpu_en every 4th clock, mem_en every 2nd clock, cycle_count=3.
- step pulse from IDLE → exactly 1 cpu_en and 2 mem_en; done coincides with cpu_en; busy is high for 4 clocks; then IDLE.
- burst_start with burst_len=5 → 5 cpu_en pulses, then done; a step pulse mid-burst is ignored; cycle_count=5.
- burst_len=0 → no cpu_en; done pulses 1 clock later; busy stays 0.
- halt raised at phase 1 during RUN → the cycle completes with cpu_en at phase 3, then IDLE; no done pulse.
- Reset asserted at phase 2 → all outputs immediately 0; cycle_count=0. Wrap test: CNT_W=4, 17 cycles → cycle_count=1.

Source files
------------

// File: rtl/sc_clock_ctrl.sv
// Clock-phase controller: turns one board clock into CPU and memory enables.
// Supports run, halt, single-step and N-step burst modes plus a cycle counter.
module sc_clock_ctrl #(
    parameter int CPU_DIV     = 4,
    parameter int MEM_PER_CPU = 2,
    parameter int CNT_W       = 32,
    parameter int BURST_W     = 16,
    localparam int PH_W       = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt,
    output logic               cpu_en,
    output logic               mem_en,
    output logic [PH_W-1:0]    phase,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, STEP, BURST} state_t;

    localparam int M = CPU_DIV / MEM_PER_CPU;
    localparam logic [PH_W-1:0] LAST = PH_W'(CPU_DIV - 1);

    state_t             state;
    logic [BURST_W-1:0] remaining;
    logic               boundary;
    logic               mem_hit;

    assign boundary = (phase == LAST);
    assign mem_hit  = ((int'(phase) % M) == (M - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            cpu_en      <= 1'b0;
            mem_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            remaining   <= '0;
        end else begin
            cpu_en <= 1'b0;
            mem_en <= 1'b0;
            done   <= 1'b0;
            if (state == IDLE) begin
                phase <= '0;
                if (halt) begin
                    state <= IDLE;
                end else if (burst_start) begin
                    if (burst_len == '0) begin
                        done <= 1'b1;
                    end else begin
                        remaining <= burst_len;
                        state     <= BURST;
                        busy      <= 1'b1;
                    end
                end else if (step) begin
                    state <= STEP;
                    busy  <= 1'b1;
                end else if (run) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                mem_en <= mem_hit;
                if (boundary) begin
                    // Mode changes only here, so a CPU cycle is never cut short.
                    phase       <= '0;
                    cpu_en      <= 1'b1;
                    cycle_count <= cycle_count + 1'b1;
                    unique case (state)
                        RUN: begin
                            if (halt || !run) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        STEP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        BURST: begin
                            if (halt) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else if (remaining == BURST_W'(1)) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                remaining <= '0;
                            end else begin
                                remaining <= remaining - 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule
